mac_stream_unit: RTL and testbench

Parametrised AXI-Stream multiply-accumulate engine that computes one dot-product-plus-bias per vector: out = sat((b + Σ over beats, Σ over lanes i[l]·k[l]) >>> SHIFT).
Successor to the single-lane 8-bit accumulator/control pair, adding:
- signed arithmetic
- LANES parallel multipliers per beat
- vector termination by i_tlast
- wide accumulator with arithmetic shift and saturation to the output width

Sits between the input/weight/bias streamers and the activation/writeback stage of the neuron datapath.

---
 rtl/mac_stream_unit_if.sv | 33 +++
 rtl/mac_stream_unit.sv | 121 ++++++++++++
 tb/tb_mac_stream_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mac_stream_unit_if.sv
// rtl/mac_stream_unit_if.sv - stream bundle for the MAC engine (input, weight, bias, result)
interface mac_stream_unit_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 2,
    parameter int BIAS_W = 8,
    parameter int OUT_W  = 8
);
    logic                    i_tvalid;
    logic                    i_tready;
    logic [LANES*DATA_W-1:0] i_tdata;
    logic                    i_tlast;
    logic                    k_tvalid;
    logic                    k_tready;
    logic [LANES*DATA_W-1:0] k_tdata;
    logic                    b_tvalid;
    logic                    b_tready;
    logic [BIAS_W-1:0]       b_tdata;
    logic                    o_tvalid;
    logic                    o_tready;
    logic [OUT_W-1:0]        o_tdata;

    // master: the streamers and writeback stage around the engine
    modport master (
        output i_tvalid, i_tdata, i_tlast, k_tvalid, k_tdata, b_tvalid, b_tdata, o_tready,
        input  i_tready, k_tready, b_tready, o_tvalid, o_tdata
    );

    // slave: the MAC engine itself
    modport slave (
        input  i_tvalid, i_tdata, i_tlast, k_tvalid, k_tdata, b_tvalid, b_tdata, o_tready,
        output i_tready, k_tready, b_tready, o_tvalid, o_tdata
    );
endinterface

// File: rtl/mac_stream_unit.sv
// rtl/mac_stream_unit.sv - signed multi-lane stream MAC with bias, shift and saturation; MAC_RELU_EN clamps negatives to 0
module mac_stream_unit #(
    parameter int DATA_W = 8,
    parameter int LANES  = 2,
    parameter int ACC_W  = 24,
    parameter int BIAS_W = 8,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    mac_stream_unit_if.slave     bus,
    output logic                 busy
);
    localparam int PW = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    // Clamp limits of the output width, expressed at accumulator width
    localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [OUT_W-1:0]   o_tdata_q, o_tdata_d;
    logic                      o_tvalid_q, o_tvalid_d;

    logic signed [PW-1:0]      a_ext, w_ext, prod;
    logic signed [ACC_W-1:0]   beat_sum, acc_sum, shifted;
    logic signed [OUT_W-1:0]   sat_val, res_val;
    logic                      beat;

    always_comb begin
        beat_sum = '0;
        a_ext    = '0;
        w_ext    = '0;
        prod     = '0;
        for (int l = 0; l < LANES; l++) begin
            a_ext    = PW'($signed(bus.i_tdata[l*DATA_W +: DATA_W]));
            w_ext    = PW'($signed(bus.k_tdata[l*DATA_W +: DATA_W]));
            prod     = a_ext * w_ext;
            beat_sum = beat_sum + ACC_W'(prod);
        end
        acc_sum = acc_q + beat_sum;
        shifted = acc_sum >>> SHIFT;
        if (shifted > OMAX)
            sat_val = OMAX[OUT_W-1:0];
        else if (shifted < OMIN)
            sat_val = OMIN[OUT_W-1:0];
        else
            sat_val = shifted[OUT_W-1:0];
`ifdef MAC_RELU_EN
        res_val = sat_val[OUT_W-1] ? '0 : sat_val;
`else
        res_val = sat_val;
`endif
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        o_tdata_d    = o_tdata_q;
        o_tvalid_d   = o_tvalid_q;
        bus.b_tready = 1'b0;
        bus.i_tready = 1'b0;
        bus.k_tready = 1'b0;
        beat         = 1'b0;
        case (state_q)
            IDLE: begin
                bus.b_tready = 1'b1;
                if (bus.b_tvalid) begin
                    acc_d   = ACC_W'($signed(bus.b_tdata));
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // Each ready depends on the other stream's valid so i and k advance only together
                bus.i_tready = bus.k_tvalid;
                bus.k_tready = bus.i_tvalid;
                beat         = bus.i_tvalid & bus.k_tvalid;
                if (beat) begin
                    acc_d = acc_sum;
                    if (bus.i_tlast) begin
                        o_tdata_d  = res_val;
                        o_tvalid_d = 1'b1;
                        state_d    = OUT;
                    end
                end
            end
            OUT: begin
                if (bus.o_tready) begin
                    o_tvalid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            o_tdata_q  <= '0;
            o_tvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            o_tdata_q  <= o_tdata_d;
            o_tvalid_q <= o_tvalid_d;
        end
    end

    assign bus.o_tdata  = o_tdata_q;
    assign bus.o_tvalid = o_tvalid_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_mac_stream_unit.sv
// tb/tb_mac_stream_unit.sv - directed self-checking bench for mac_stream_unit
module tb_mac_stream_unit;
    logic clk;
    logic reset;
    logic busy;
    int   checks;
    int   failures;

    mac_stream_unit_if #(.DATA_W(8), .LANES(2), .BIAS_W(8), .OUT_W(8)) bus ();

    mac_stream_unit #(
        .DATA_W(8), .LANES(2), .ACC_W(24), .BIAS_W(8), .OUT_W(8), .SHIFT(0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bias(input logic [7:0] b);
        bus.b_tvalid = 1'b1;
        bus.b_tdata  = b;
        #1;
        check("bias_ready", 32'(bus.b_tready), 32'd1);
        tick();
        bus.b_tvalid = 1'b0;
        #1;
        check("busy_after_bias", 32'(busy), 32'd1);
    endtask

    task automatic send_beat(input logic [7:0] i0, input logic [7:0] i1,
                             input logic [7:0] k0, input logic [7:0] k1, input logic last);
        bus.i_tvalid = 1'b1;
        bus.k_tvalid = 1'b1;
        bus.i_tdata  = {i1, i0};
        bus.k_tdata  = {k1, k0};
        bus.i_tlast  = last;
        #1;
        check("beat_ready", {30'd0, bus.i_tready, bus.k_tready}, 32'd3);
        tick();
        bus.i_tvalid = 1'b0;
        bus.k_tvalid = 1'b0;
        bus.i_tlast  = 1'b0;
    endtask

    task automatic take_result(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(bus.o_tvalid), 32'd1);
        check({tag, "_data"}, 32'(bus.o_tdata), 32'(exp));
        bus.o_tready = 1'b1;
        tick();
        bus.o_tready = 1'b0;
        #1;
        check({tag, "_idle"}, {30'd0, bus.o_tvalid, busy}, 32'd0);
        check({tag, "_bready"}, 32'(bus.b_tready), 32'd1);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        bus.i_tvalid = 1'b0;
        bus.k_tvalid = 1'b0;
        bus.b_tvalid = 1'b0;
        bus.i_tdata  = '0;
        bus.k_tdata  = '0;
        bus.b_tdata  = '0;
        bus.i_tlast  = 1'b0;
        bus.o_tready = 1'b0;
        tick();
        tick();
        check("rst_out", {22'd0, bus.o_tvalid, bus.o_tdata, busy}, 32'd0);
        check("rst_ready", {29'd0, bus.b_tready, bus.i_tready, bus.k_tready}, 32'd4);
        reset = 1'b0;
        tick();

        // 1: bias 5, beats (3*4 + 2*-1) + (1*1 + 0*7) -> 16
        send_bias(8'd5);
        send_beat(8'd3, 8'd2, 8'd4, 8'hFF, 1'b0);
        check("t1_not_yet", 32'(bus.o_tvalid), 32'd0);
        send_beat(8'd1, 8'd0, 8'd1, 8'd7, 1'b1);
        take_result("t1", 8'd16);

        // 2: 100 + 2*127*127 = 32358 saturates to 127
        send_bias(8'd100);
        send_beat(8'd127, 8'd127, 8'd127, 8'd127, 1'b1);
        take_result("t2", 8'd127);

        // 3: -100 + -128*127 = -16356 saturates to -128
        send_bias(8'h9C);
        send_beat(8'h80, 8'd0, 8'd127, 8'd0, 1'b1);
`ifdef MAC_RELU_EN
        take_result("t3", 8'h00);
`else
        take_result("t3", 8'h80);
`endif

        // 4: i valid without k for 4 cycles; tlast high must not end the vector
        send_bias(8'd5);
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = {8'd2, 8'd3};
        bus.k_tdata  = {8'hFF, 8'd4};
        bus.i_tlast  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("t4_stall_ready", {30'd0, bus.i_tready, bus.k_tready}, 32'd1);
            tick();
        end
        check("t4_stall_out", 32'(bus.o_tvalid), 32'd0);
        bus.i_tlast = 1'b0;
        send_beat(8'd3, 8'd2, 8'd4, 8'hFF, 1'b0);
        check("t4_one_beat", 32'(bus.o_tvalid), 32'd0);
        send_beat(8'd1, 8'd0, 8'd1, 8'd7, 1'b1);

        // 5: result backpressure with all other valids asserted
        bus.i_tvalid = 1'b1;
        bus.k_tvalid = 1'b1;
        bus.b_tvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t5_hold", {21'd0, bus.o_tvalid, bus.o_tdata, bus.b_tready, bus.i_tready, bus.k_tready},
                  {21'd0, 1'b1, 8'd16, 3'b000});
            tick();
        end
        bus.i_tvalid = 1'b0;
        bus.k_tvalid = 1'b0;
        bus.b_tvalid = 1'b0;
        take_result("t5", 8'd16);

        // 6: reset after 1 of 3 beats, then a fresh vector 1 + 1 + 1 = 3
        send_bias(8'd7);
        send_beat(8'd5, 8'd5, 8'd5, 8'd5, 1'b0);
        reset = 1'b1;
        #1;
        check("t6_reset", {22'd0, bus.o_tvalid, bus.o_tdata, busy}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        send_bias(8'd1);
        send_beat(8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
        take_result("t6", 8'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
